// File: rtl/input_dispatcher_if.sv
// Bus bundle between the FWFT input FIFO read port, the dispatcher and the
// destination units. The master side is the dispatcher.
interface input_dispatcher_if #(
  parameter int N_UNITS = 4
) ();
  logic [7:0]         fifo_dout;
  logic               fifo_empty;
  logic               fifo_rd_en;
  logic [N_UNITS-1:0] unit_idle;
  logic [N_UNITS-1:0] unit_full;
  logic [N_UNITS-1:0] unit_start;
  logic [7:0]         unit_type;
  logic [N_UNITS-1:0] unit_wr_en;
  logic [7:0]         unit_dout;
  logic               unit_last;
  logic               err_type;
  logic               err_len;
  logic [15:0]        pkt_count;

  modport master (
    input  fifo_dout, fifo_empty, unit_idle, unit_full,
    output fifo_rd_en, unit_start, unit_type, unit_wr_en, unit_dout,
           unit_last, err_type, err_len, pkt_count
  );

  modport slave (
    output fifo_dout, fifo_empty, unit_idle, unit_full,
    input  fifo_rd_en, unit_start, unit_type, unit_wr_en, unit_dout,
           unit_last, err_type, err_len, pkt_count
  );
endinterface

// File: rtl/input_dispatcher.sv
// Packet dispatcher: parses a 3-byte header from the FWFT FIFO, grants an idle
// unit round-robin and streams the payload to it under per-unit backpressure.
// Malformed headers park the FSM in ERROR until reset.
module input_dispatcher #(
  parameter int N_UNITS = 4,
  parameter int MAX_LEN = 4096
) (
  input logic               clk,
  input logic               rst_n,
  input_dispatcher_if.master bus
);

  localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  typedef enum logic [2:0] {HDR0, HDR1, HDR2, SELECT, PAYLOAD, ERROR} state_t;

  state_t             state_r, state_s;
  logic [7:0]         hdr_type_r;
  logic [7:0]         unit_type_r;
  logic [7:0]         len_lo_r;
  logic [15:0]        len_r;
  logic [15:0]        remaining_r;
  logic [IDX_W-1:0]   sel_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [N_UNITS-1:0] start_r;
  logic               err_type_r;
  logic               err_len_r;
  logic [15:0]        pkt_count_r;

  logic               rd_en_s;
  logic               xfer_s;
  logic               last_s;
  logic [N_UNITS-1:0] wr_en_s;
  logic [15:0]        len_s;
  logic               len_bad_s;
  logic               grant_valid_s;
  logic [IDX_W-1:0]   grant_idx_s;
  int                 scan_s;

  // Full length is formed from the live FIFO head while sitting in HDR2.
  assign len_s     = {bus.fifo_dout, len_lo_r};
  assign len_bad_s = (len_s == 16'd0) || ({16'd0, len_s} > 32'(MAX_LEN));

  // Round-robin search: first idle unit after the previous grant, wrapping.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = '0;
    scan_s        = 0;
    for (int k = 1; k <= N_UNITS; k++) begin
      scan_s = (int'(rr_ptr_r) + k) % N_UNITS;
      if (!grant_valid_s && bus.unit_idle[scan_s]) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = IDX_W'(scan_s);
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Next-state and combinational pop/strobe generation for single-cycle FWFT pops.
  always_comb begin
    state_s = state_r;
    rd_en_s = 1'b0;
    xfer_s  = 1'b0;
    last_s  = 1'b0;
    wr_en_s = '0;
    case (state_r)
      HDR0: begin
        if (!bus.fifo_empty) begin
          rd_en_s = 1'b1;
          if (bus.fifo_dout == 8'd0) state_s = ERROR;
          else                       state_s = HDR1;
        end else begin
          state_s = HDR0;
        end
      end
      HDR1: begin
        if (!bus.fifo_empty) begin
          rd_en_s = 1'b1;
          state_s = HDR2;
        end else begin
          state_s = HDR1;
        end
      end
      HDR2: begin
        if (!bus.fifo_empty) begin
          rd_en_s = 1'b1;
          if (len_bad_s) state_s = ERROR;
          else           state_s = SELECT;
        end else begin
          state_s = HDR2;
        end
      end
      SELECT: begin
        if (grant_valid_s) state_s = PAYLOAD;
        else               state_s = SELECT;
      end
      PAYLOAD: begin
        xfer_s  = !bus.fifo_empty && !bus.unit_full[sel_r];
        rd_en_s = xfer_s;
        if (xfer_s) begin
          wr_en_s[sel_r] = 1'b1;
          if (remaining_r == 16'd1) begin
            last_s  = 1'b1;
            state_s = HDR0;
          end else begin
            state_s = PAYLOAD;
          end
        end else begin
          state_s = PAYLOAD;
        end
      end
      ERROR:   state_s = ERROR;
      default: state_s = HDR0;
    endcase
  end

  // State register plus header capture, grant bookkeeping and packet counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= HDR0;
      hdr_type_r  <= 8'd0;
      unit_type_r <= 8'd0;
      len_lo_r    <= 8'd0;
      len_r       <= 16'd0;
      remaining_r <= 16'd0;
      sel_r       <= '0;
      rr_ptr_r    <= IDX_W'(N_UNITS - 1);
      start_r     <= '0;
      err_type_r  <= 1'b0;
      err_len_r   <= 1'b0;
      pkt_count_r <= 16'd0;
    end else begin
      state_r <= state_s;
      start_r <= '0;
      case (state_r)
        HDR0: begin
          if (rd_en_s) begin
            if (bus.fifo_dout == 8'd0) err_type_r <= 1'b1;
            else                       hdr_type_r <= bus.fifo_dout;
          end
        end
        HDR1: begin
          if (rd_en_s) len_lo_r <= bus.fifo_dout;
        end
        HDR2: begin
          if (rd_en_s) begin
            len_r <= len_s;
            if (len_bad_s) err_len_r <= 1'b1;
          end
        end
        SELECT: begin
          if (grant_valid_s) begin
            rr_ptr_r             <= grant_idx_s;
            sel_r                <= grant_idx_s;
            remaining_r          <= len_r;
            unit_type_r          <= hdr_type_r;
            start_r[grant_idx_s] <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (xfer_s) begin
            remaining_r <= remaining_r - 16'd1;
            if (last_s) pkt_count_r <= pkt_count_r + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.unit_wr_en = wr_en_s;
  assign bus.unit_dout  = bus.fifo_dout;
  assign bus.unit_last  = last_s;
  assign bus.unit_start = start_r;
  assign bus.unit_type  = unit_type_r;
  assign bus.err_type   = err_type_r;
  assign bus.err_len    = err_len_r;
  assign bus.pkt_count  = pkt_count_r;

endmodule

// File: tb/tb_input_dispatcher.sv
// Directed bench for input_dispatcher: a queue models the FWFT FIFO, unit
// writes and start pulses are logged, and each test task checks its results.
module tb_input_dispatcher;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_dispatcher_if #(.N_UNITS(4)) ifc ();
  input_dispatcher #(.N_UNITS(4), .MAX_LEN(4096)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit gap = 1'b0;
  logic [7:0] rx_data[$];
  int rx_unit[$];
  bit rx_last[$];
  int starts[$];
  logic cap_rd, cap_last;
  logic [3:0] cap_wr, cap_start;

  function automatic int onehot_idx(logic [3:0] v);
    case (v)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic drive_fifo();
    ifc.fifo_empty = (q.size() == 0) || gap;
    ifc.fifo_dout  = (q.size() != 0) ? q[0] : 8'hEE;
  endtask

  // One clock: drive FIFO, sample outputs mid-cycle, log, pop on the edge.
  task automatic tick();
    drive_fifo();
    #1;
    cap_rd = ifc.fifo_rd_en; cap_wr = ifc.unit_wr_en;
    cap_last = ifc.unit_last; cap_start = ifc.unit_start;
    if (cap_wr != 4'd0) begin
      rx_data.push_back(ifc.unit_dout);
      rx_unit.push_back(onehot_idx(cap_wr));
      rx_last.push_back(cap_last);
    end
    if (cap_start != 4'd0) starts.push_back(onehot_idx(cap_start));
    @(posedge clk);
    if (cap_rd === 1'b1 && q.size() > 0) q.delete(0);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; q.delete(); gap = 1'b0;
    ifc.unit_idle = 4'hF; ifc.unit_full = 4'h0;
    tick(); tick();
    rst_n = 1'b1;
    rx_data.delete(); rx_unit.delete(); rx_last.delete(); starts.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    checks++; if ({cap_rd, cap_wr, cap_start, cap_last} !== 10'd0) begin errors++; $display("FAIL reset_strobes: got %b want 0", {cap_rd, cap_wr, cap_start, cap_last}); end
    checks++; if (ifc.unit_type !== 8'h00) begin errors++; $display("FAIL reset_type: got %h want 00", ifc.unit_type); end
    checks++; if ({ifc.err_type, ifc.err_len} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {ifc.err_type, ifc.err_len}); end
    checks++; if (ifc.pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt: got %0d want 0", ifc.pkt_count); end
  endtask

  task automatic test_single();
    logic [7:0] exp[3];
    int n;
    exp = '{8'hAA, 8'hBB, 8'hCC};
    apply_reset();
    q = '{8'h01, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    n = 0;
    while (rx_data.size() < 3 && n < 20) begin tick(); n++; end
    checks++; if (n != 7) begin errors++; $display("FAIL single_cycles: got %0d want 7", n); end
    checks++; if (starts.size() != 1 || starts[0] != 0) begin errors++; $display("FAIL single_start: got %0d starts want 1 to unit 0", starts.size()); end
    for (int i = 0; i < 3 && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp[i] || rx_unit[i] != 0 || rx_last[i] != (i == 2)) begin
        errors++; $display("FAIL single_byte%0d: got %h u%0d l%0d want %h u0 l%0d", i, rx_data[i], rx_unit[i], rx_last[i], exp[i], (i == 2));
      end
    end
    checks++; if (ifc.unit_type !== 8'h01) begin errors++; $display("FAIL single_type: got %h want 01", ifc.unit_type); end
    checks++; if (ifc.pkt_count !== 16'd1) begin errors++; $display("FAIL single_pkt: got %0d want 1", ifc.pkt_count); end
  endtask

  task automatic test_round_robin_back_to_back();
    int exp_u[5];
    int n;
    exp_u = '{0, 1, 2, 3, 0};
    apply_reset();
    for (int p = 0; p < 5; p++) begin
      q.push_back(8'h01); q.push_back(8'h01); q.push_back(8'h00); q.push_back(8'h10 + 8'(p));
    end
    n = 0;
    while (rx_data.size() < 5 && n < 50) begin tick(); n++; end
    checks++; if (n != 25) begin errors++; $display("FAIL b2b_cycles: got %0d want 25", n); end
    for (int i = 0; i < 5 && i < rx_data.size() && i < starts.size(); i++) begin
      checks++;
      if (starts[i] != exp_u[i] || rx_unit[i] != exp_u[i] || rx_data[i] !== 8'h10 + 8'(i) || !rx_last[i]) begin
        errors++; $display("FAIL rr_grant%0d: got start u%0d wr u%0d data %h want u%0d data %h", i, starts[i], rx_unit[i], rx_data[i], exp_u[i], 8'h10 + 8'(i));
      end
    end
    ifc.unit_idle = 4'b0101;
    starts.delete(); rx_data.delete(); rx_unit.delete(); rx_last.delete();
    q = '{8'h01, 8'h01, 8'h00, 8'h20, 8'h01, 8'h01, 8'h00, 8'h21};
    n = 0;
    while (rx_data.size() < 2 && n < 20) begin tick(); n++; end
    checks++; if (starts.size() != 2 || starts[0] != 2 || starts[1] != 0) begin errors++; $display("FAIL rr_masked: got %0d starts first u%0d want u2 then u0", starts.size(), starts.size() > 0 ? starts[0] : -1); end
    checks++; if (ifc.pkt_count !== 16'd7) begin errors++; $display("FAIL rr_pkt: got %0d want 7", ifc.pkt_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[4];
    int n, pre;
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    apply_reset();
    q = '{8'h02, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    n = 0;
    while (rx_data.size() < 4 && n < 60) begin
      ifc.unit_full = (n % 2 == 1) ? 4'hF : 4'h0;
      gap = (n % 3 == 2);
      pre = q.size();
      tick();
      if (pre <= 4 && (ifc.unit_full[0] || ifc.fifo_empty)) begin
        checks++; if (cap_rd !== 1'b0) begin errors++; $display("FAIL bp_pop_blocked: got rd %b want 0 at step %0d", cap_rd, n); end
      end
      n++;
    end
    ifc.unit_full = 4'h0; gap = 1'b0;
    checks++; if (rx_data.size() != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", rx_data.size()); end
    for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
      checks++;
      if (rx_data[i] !== exp[i] || rx_unit[i] != 0 || rx_last[i] != (i == 3)) begin
        errors++; $display("FAIL bp_byte%0d: got %h u%0d l%0d want %h u0 l%0d", i, rx_data[i], rx_unit[i], rx_last[i], exp[i], (i == 3));
      end
    end
    checks++; if (ifc.pkt_count !== 16'd1) begin errors++; $display("FAIL bp_pkt: got %0d want 1", ifc.pkt_count); end
  endtask

  task automatic test_no_idle();
    int n;
    apply_reset();
    ifc.unit_idle = 4'h0;
    q = '{8'h03, 8'h02, 8'h00, 8'h55, 8'h66};
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (cap_rd !== 1'b0 || cap_start !== 4'd0) begin errors++; $display("FAIL noidle_hold%0d: got rd %b start %b want 0", i, cap_rd, cap_start); end
    end
    checks++; if (q.size() != 2) begin errors++; $display("FAIL noidle_fifo: got %0d want 2", q.size()); end
    ifc.unit_idle = 4'b1000;
    tick();
    tick();
    checks++; if (cap_start !== 4'b1000) begin errors++; $display("FAIL noidle_grant: got %b want 1000", cap_start); end
    ifc.unit_idle = 4'hF;
    n = 0;
    while (rx_data.size() < 2 && n < 10) begin tick(); n++; end
    checks++; if (rx_data.size() != 2 || rx_unit[0] != 3 || rx_data[0] !== 8'h55 || rx_data[1] !== 8'h66 || !rx_last[1]) begin errors++; $display("FAIL noidle_data: got %0d bytes first %h u%0d want 55 66 to u3", rx_data.size(), rx_data.size() > 0 ? rx_data[0] : 8'h00, rx_unit.size() > 0 ? rx_unit[0] : -1); end
    checks++; if (ifc.unit_type !== 8'h03) begin errors++; $display("FAIL noidle_type: got %h want 03", ifc.unit_type); end
  endtask

  task automatic test_errors();
    bit any_rd;
    apply_reset();
    q = '{8'h00, 8'h01, 8'h01, 8'h00, 8'hAA};
    tick();
    any_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (cap_rd !== 1'b0) any_rd = 1'b1; end
    checks++; if (any_rd || q.size() != 4) begin errors++; $display("FAIL errtype_nopop: got fifo %0d want 4", q.size()); end
    checks++; if ({ifc.err_type, ifc.err_len} !== 2'b10) begin errors++; $display("FAIL errtype_flags: got %b want 10", {ifc.err_type, ifc.err_len}); end
    apply_reset();
    checks++; if ({ifc.err_type, ifc.err_len} !== 2'b00) begin errors++; $display("FAIL err_cleared: got %b want 00", {ifc.err_type, ifc.err_len}); end
    q = '{8'h01, 8'h00, 8'h00, 8'h07};
    for (int i = 0; i < 6; i++) tick();
    checks++; if ({ifc.err_type, ifc.err_len} !== 2'b01 || q.size() != 1) begin errors++; $display("FAIL errlen_zero: got %b fifo %0d want 01 fifo 1", {ifc.err_type, ifc.err_len}, q.size()); end
    apply_reset();
    q = '{8'h01, 8'h01, 8'h10};
    for (int i = 0; i < 4; i++) tick();
    checks++; if (ifc.err_len !== 1'b1) begin errors++; $display("FAIL errlen_4097: got %b want 1", ifc.err_len); end
    apply_reset();
    q = '{8'h01, 8'h00, 8'h10, 8'h5A};
    for (int i = 0; i < 5; i++) tick();
    checks++; if (ifc.err_len !== 1'b0 || starts.size() != 1) begin errors++; $display("FAIL len_4096_ok: got err %b starts %0d want 0 and 1", ifc.err_len, starts.size()); end
  endtask

  task automatic test_reset_mid();
    bit saw_last;
    int n;
    apply_reset();
    q = '{8'h01, 8'h05, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    n = 0;
    while (rx_data.size() < 1 && n < 10) begin tick(); n++; end
    rst_n = 1'b0;
    tick();
    q.delete();
    tick();
    checks++; if ({cap_rd, cap_wr, cap_start, cap_last} !== 10'd0) begin errors++; $display("FAIL rstmid_strobes: got %b want 0", {cap_rd, cap_wr, cap_start, cap_last}); end
    checks++; if (ifc.unit_type !== 8'h00 || ifc.pkt_count !== 16'd0) begin errors++; $display("FAIL rstmid_regs: got type %h pkt %0d want 00 0", ifc.unit_type, ifc.pkt_count); end
    saw_last = 1'b0;
    foreach (rx_last[i]) if (rx_last[i]) saw_last = 1'b1;
    checks++; if (saw_last) begin errors++; $display("FAIL rstmid_last: got last seen want none"); end
    rst_n = 1'b1;
    rx_data.delete(); rx_unit.delete(); rx_last.delete(); starts.delete();
    q = '{8'h04, 8'h01, 8'h00, 8'h77};
    n = 0;
    while (rx_data.size() < 1 && n < 10) begin tick(); n++; end
    checks++; if (rx_data.size() != 1 || rx_data[0] !== 8'h77 || rx_unit[0] != 0 || !rx_last[0]) begin errors++; $display("FAIL rstmid_next: got %0d bytes want 77 last to u0", rx_data.size()); end
    checks++; if (ifc.unit_type !== 8'h04 || ifc.pkt_count !== 16'd1) begin errors++; $display("FAIL rstmid_next_regs: got type %h pkt %0d want 04 1", ifc.unit_type, ifc.pkt_count); end
  endtask

  initial begin
    ifc.unit_idle = 4'hF; ifc.unit_full = 4'h0;
    ifc.fifo_empty = 1'b1; ifc.fifo_dout = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin_back_to_back();
    test_backpressure();
    test_no_idle();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
